// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded fields from ID, inserts bubbles for
// flush and load-use hazards, freezes on stall/wfi, and counts inserted bubbles.
module id_ex_reg #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            wfi,
    input  logic            flush,
    input  logic            load_use_hazard,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [2:0]      id_funct3,
    input  logic [3:0]      id_alu_op,
    input  logic            id_memread,
    input  logic            id_memwrite,
    input  logic            id_regwrite,
    input  logic            id_branch,
    input  logic            id_jump,
    input  logic            id_alusrc,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic [3:0]      ex_alu_op,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_regwrite,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_alusrc,
    output logic            ex_valid,
    output logic [15:0]     bubble_cnt
);

    logic hold;
    logic bubble;
    logic load_valid;

    assign hold       = stall | wfi;
    assign bubble     = flush | load_use_hazard;
    assign load_valid = id_valid & ~bubble;

    // A squashed or invalid slot carries no control and a zero rd, so downstream
    // forwarding/hazard compares can never match a bubble except on x0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct3   <= '0;
            ex_alu_op   <= '0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_jump     <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_valid    <= 1'b0;
            bubble_cnt  <= '0;
        end else if (!hold) begin
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_funct3   <= id_funct3;
            ex_alu_op   <= id_alu_op;
            ex_valid    <= load_valid;
            ex_memread  <= load_valid & id_memread;
            ex_memwrite <= load_valid & id_memwrite;
            ex_regwrite <= load_valid & id_regwrite;
            ex_branch   <= load_valid & id_branch;
            ex_jump     <= load_valid & id_jump;
            ex_alusrc   <= load_valid & id_alusrc;
            ex_rd       <= (load_valid && id_regwrite) ? id_rd : 5'd0;
            // Flush and load-use in the same cycle are one bubble; count saturates.
            if (bubble && bubble_cnt != 16'hFFFF) begin
                bubble_cnt <= bubble_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter XLEN, default 32, datapath width of PC, operand and immediate fields.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stall  input  1  global memory stall; freezes stage.
REQ-005 wfi  input  1  wait-for-interrupt hold; freezes stage, same effect as stall.
REQ-006 flush  input  1  taken branch/jump redirect from EX; squashes incoming ID instruction.
REQ-007 load_use_hazard  input  1  from hazard unit; inserts one bubble into EX.
REQ-008 id_valid  input  1  ID holds a real instruction.
REQ-009 id_pc, id_rs1_data, id_rs2_data, id_imm  input  XLEN each  decoded PC, register operands, immediate.
REQ-010 id_rs1, id_rs2, id_rd  input  5 each  register indices.
REQ-011 id_funct3 input 3, id_alu_op input 4  ALU/memory-size control.
REQ-012 id_memread, id_memwrite, id_regwrite, id_branch, id_jump, id_alusrc  input  1 each  control bits.
REQ-013 ex_* outputs  output  same widths as REQ-009..REQ-012  registered copies of each id_* field.
REQ-014 ex_valid  output  1  EX holds a real instruction.
REQ-015 bubble_cnt  output  16  count of bubbles inserted (load-use plus flush).

Function
REQ-016 All ex_* outputs and ex_valid SHALL be registered; latency ID->EX one cycle.
REQ-017 Update priority each edge SHALL be: rst > (stall|wfi) hold > flush > load_use_hazard > normal load.
REQ-018 Hold: every ex_* output, ex_valid and bubble_cnt SHALL retain its value; flush and load_use_hazard ignored that cycle (not remembered).
REQ-019 Flush: ex_valid<=0, ex_memread/ex_memwrite/ex_regwrite/ex_branch/ex_jump<=0, ex_rd<=0; data fields unchanged-value don't-care but SHALL be loaded from ID.
REQ-020 Load-use bubble: identical side effects to REQ-019 (control and ex_rd zeroed, ex_valid<=0).
REQ-021 Flush and load_use_hazard together SHALL produce exactly one bubble and one increment.
REQ-022 Normal load: all ex_* <= id_*, ex_valid <= id_valid; when id_valid=0, control bits and ex_rd SHALL be forced to 0.
REQ-023 ex_rd SHALL be 0 whenever ex_regwrite=0 or ex_valid=0, so downstream hazard compare never matches a bubble except on x0.
REQ-024 bubble_cnt SHALL increment by 1 on each REQ-019/REQ-020 cycle and saturate at 16'hFFFF (no wrap).
REQ-025 Control bits SHALL never be asserted with ex_valid=0.

Reset
REQ-026 On rst: ex_valid=0, all ex_* control bits=0, ex_rd/ex_rs1/ex_rs2=0, ex_pc/ex_rs1_data/ex_rs2_data/ex_imm=0, ex_funct3=0, ex_alu_op=0, bubble_cnt=0.
REQ-027 rst asserted during stall, flush or hazard SHALL win; first post-reset edge SHALL perform a normal load.

Verification
REQ-028 Normal: id_valid=1, id_pc=0x100, id_rd=5, id_regwrite=1 -> next cycle ex_pc=0x100, ex_rd=5, ex_regwrite=1, ex_valid=1.
REQ-029 Load-use: load_use_hazard=1 with id_rd=7, id_memread=1 -> ex_valid=0, ex_memread=0, ex_rd=0, bubble_cnt 0->1.
REQ-030 Stall over hazard: stall=1 and load_use_hazard=1 for 3 cycles with EX holding pc 0x200 -> ex_pc stays 0x200, ex_valid stays 1, bubble_cnt unchanged.
REQ-031 Simultaneous flush+load_use_hazard -> single bubble, bubble_cnt +1 only.
REQ-032 Saturation: preload bubble_cnt to 0xFFFE via 0xFFFE bubbles, two more bubbles -> 0xFFFF, stays 0xFFFF.
REQ-033 Reset mid-stall: stall=1, rst=1 with ex_valid=1 -> all outputs zero next edge; rst=0, stall=0, id_valid=1, id_pc=0x4 -> ex_pc=0x4, ex_valid=1 following edge.
